// File: rtl/lift_pkg.sv
// Shared types and floor-mask helpers for the lift dispatcher.
package lift_pkg;

    // Default building height; instances may override through their parameter.
    localparam int N_FLOORS_DEFAULT = 12;

    // Masks are handled internally at a fixed maximum width so the helpers
    // work for any instance height up to this limit.
    localparam int MAX_FLOORS = 32;
    typedef logic [MAX_FLOORS-1:0] floor_mask_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE_UP,
        ST_MOVE_DN,
        ST_DOOR_OPEN
    } lift_state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DN
    } lift_dir_t;

    // Bits of q strictly above the floor marked by one-hot pos.
    function automatic floor_mask_t mask_above(input floor_mask_t pos, input floor_mask_t q);
        return q & ~((pos << 1) - floor_mask_t'(1));
    endfunction

    // Bits of q strictly below the floor marked by one-hot pos.
    function automatic floor_mask_t mask_below(input floor_mask_t pos, input floor_mask_t q);
        return q & (pos - floor_mask_t'(1));
    endfunction

endpackage

// File: rtl/lift_timer.sv
// Loadable down-counter; o_done is high while the count rests at zero.
// Loading N-1 makes the owner see o_done exactly N clocks after the load edge.
module lift_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    // Load takes priority; otherwise count down and hold at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/lift_dispatcher.sv
// Per-car dispatcher: consumes the request masks, moves the car floor by
// floor, opens the door on arrival and strobes the clears for that floor.
module lift_dispatcher
    import lift_pkg::*;
#(
    parameter int N_FLOORS      = lift_pkg::N_FLOORS_DEFAULT,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] i_up_queue,
    input  logic [N_FLOORS-1:0] i_dn_queue,
    input  logic [N_FLOORS-1:0] i_flr_queue,
    input  logic                i_door_hold,
    output logic [N_FLOORS-1:0] o_flr_pos,
    output logic                o_up_clr,
    output logic                o_dn_clr,
    output logic                o_flr_clr,
    output logic                o_door_open,
    output logic                o_move_up,
    output logic                o_move_dn
);

    localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);
    localparam logic [TMR_W-1:0] TRAVEL_LOAD = TMR_W'(TRAVEL_CYCLES - 1);
    localparam logic [TMR_W-1:0] DOOR_LOAD   = TMR_W'(DOOR_CYCLES - 1);

    lift_state_t         r_state, w_state_next;
    lift_dir_t           r_dir, w_dir_next;
    logic [N_FLOORS-1:0] r_flr_pos, w_flr_pos_next;
    logic                r_up_clr, r_dn_clr, r_door_open, r_move_up, r_move_dn;
    logic                w_svc_up_next, w_svc_dn_next;
    logic                w_travel_load, w_door_load, w_travel_done, w_door_done;

    logic [N_FLOORS-1:0] w_any, w_pos_up, w_pos_dn;
    floor_mask_t         w_any_ext;
    logic                w_here, w_above, w_below;
    logic                w_up_above, w_dn_below, w_stop_up, w_stop_dn;

    assign w_any     = i_up_queue | i_dn_queue | i_flr_queue;
    assign w_any_ext = floor_mask_t'(w_any);
    assign w_here    = |(w_any & r_flr_pos);
    assign w_above   = |(mask_above(floor_mask_t'(r_flr_pos), w_any_ext));
    assign w_below   = |(mask_below(floor_mask_t'(r_flr_pos), w_any_ext));

    // Floor the car would arrive at next, and the stop decision made there.
    assign w_pos_up   = r_flr_pos << 1;
    assign w_pos_dn   = r_flr_pos >> 1;
    assign w_up_above = |(mask_above(floor_mask_t'(w_pos_up), w_any_ext));
    assign w_dn_below = |(mask_below(floor_mask_t'(w_pos_dn), w_any_ext));
    assign w_stop_up  = (|(w_pos_up & (i_flr_queue | i_up_queue)))
                      | ((|(w_pos_up & i_dn_queue)) & ~w_up_above);
    assign w_stop_dn  = (|(w_pos_dn & (i_flr_queue | i_dn_queue)))
                      | ((|(w_pos_dn & i_up_queue)) & ~w_dn_below);

    lift_timer #(.WIDTH(TMR_W)) u_travel_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_travel_load),
        .i_load_val (TRAVEL_LOAD),
        .o_done     (w_travel_done)
    );

    lift_timer #(.WIDTH(TMR_W)) u_door_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_door_load),
        .i_load_val (DOOR_LOAD),
        .o_done     (w_door_done)
    );

    // Next-state, direction, position and served-category decisions.
    always_comb begin
        w_state_next   = r_state;
        w_dir_next     = r_dir;
        w_flr_pos_next = r_flr_pos;
        w_svc_up_next  = r_up_clr;
        w_svc_dn_next  = r_dn_clr;
        w_travel_load  = 1'b0;
        w_door_load    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_here) begin
                    w_state_next  = ST_DOOR_OPEN;
                    w_svc_up_next = |(i_up_queue & r_flr_pos);
                    w_svc_dn_next = |(i_dn_queue & r_flr_pos);
                    w_door_load   = 1'b1;
                end else if (r_dir == DIR_DN && w_below) begin
                    w_state_next  = ST_MOVE_DN;
                    w_travel_load = 1'b1;
                end else if (w_above) begin
                    w_state_next  = ST_MOVE_UP;
                    w_dir_next    = DIR_UP;
                    w_travel_load = 1'b1;
                end else if (w_below) begin
                    w_state_next  = ST_MOVE_DN;
                    w_dir_next    = DIR_DN;
                    w_travel_load = 1'b1;
                end else begin
                    w_dir_next    = DIR_NONE;
                end
            end
            ST_MOVE_UP: begin
                if (w_travel_done) begin
                    w_flr_pos_next = w_pos_up;
                    if (w_stop_up) begin
                        w_state_next  = ST_DOOR_OPEN;
                        w_svc_up_next = 1'b1;
                        w_svc_dn_next = ~w_up_above;
                        w_door_load   = 1'b1;
                    end else if (w_up_above) begin
                        w_travel_load = 1'b1;
                    end else begin
                        w_state_next  = ST_IDLE;
                    end
                end
            end
            ST_MOVE_DN: begin
                if (w_travel_done) begin
                    w_flr_pos_next = w_pos_dn;
                    if (w_stop_dn) begin
                        w_state_next  = ST_DOOR_OPEN;
                        w_svc_dn_next = 1'b1;
                        w_svc_up_next = ~w_dn_below;
                        w_door_load   = 1'b1;
                    end else if (w_dn_below) begin
                        w_travel_load = 1'b1;
                    end else begin
                        w_state_next  = ST_IDLE;
                    end
                end
            end
            ST_DOOR_OPEN: begin
                if (i_door_hold) begin
                    w_door_load  = 1'b1;
                end else if (w_door_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register plus outputs registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_dir       <= DIR_NONE;
            r_flr_pos   <= N_FLOORS'(1);
            r_up_clr    <= 1'b0;
            r_dn_clr    <= 1'b0;
            r_door_open <= 1'b0;
            r_move_up   <= 1'b0;
            r_move_dn   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_dir       <= w_dir_next;
            r_flr_pos   <= w_flr_pos_next;
            r_up_clr    <= (w_state_next == ST_DOOR_OPEN) && w_svc_up_next;
            r_dn_clr    <= (w_state_next == ST_DOOR_OPEN) && w_svc_dn_next;
            r_door_open <= (w_state_next == ST_DOOR_OPEN);
            r_move_up   <= (w_state_next == ST_MOVE_UP);
            r_move_dn   <= (w_state_next == ST_MOVE_DN);
        end
    end

    assign o_flr_pos   = r_flr_pos;
    assign o_up_clr    = r_up_clr;
    assign o_dn_clr    = r_dn_clr;
    assign o_flr_clr   = r_door_open;
    assign o_door_open = r_door_open;
    assign o_move_up   = r_move_up;
    assign o_move_dn   = r_move_dn;

endmodule

// File: tb/tb_lift_dispatcher.sv
// Self-checking bench: a request-handler model feeds the dispatcher, expected
// stops are queued when requests are issued and compared on door opening.
module tb_lift_dispatcher;

    localparam int NF = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NF-1:0] up_q, dn_q, flr_q;
    logic [NF-1:0] press_up = '0, press_dn = '0, press_flr = '0, withdraw_flr = '0;
    logic          door_hold = 1'b0;
    logic [NF-1:0] o_flr_pos;
    logic          o_up_clr, o_dn_clr, o_flr_clr, o_door_open, o_move_up, o_move_dn;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic [NF-1:0] pos;
        logic          up;
        logic          dn;
        int            open_cyc;
        int            dur;
    } stop_t;

    stop_t sb[$];
    stop_t cur_stop;
    int    open_seen = 0;
    logic  door_prev = 1'b0;

    lift_dispatcher #(.N_FLOORS(NF), .TRAVEL_CYCLES(4), .DOOR_CYCLES(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_up_queue  (up_q),
        .i_dn_queue  (dn_q),
        .i_flr_queue (flr_q),
        .i_door_hold (door_hold),
        .o_flr_pos   (o_flr_pos),
        .o_up_clr    (o_up_clr),
        .o_dn_clr    (o_dn_clr),
        .o_flr_clr   (o_flr_clr),
        .o_door_open (o_door_open),
        .o_move_up   (o_move_up),
        .o_move_dn   (o_move_dn)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Request handler model: presses latch, clear strobes drop bits a clock later.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            up_q  <= '0;
            dn_q  <= '0;
            flr_q <= '0;
        end else begin
            up_q  <= (up_q | press_up) & ~(o_up_clr ? o_flr_pos : '0);
            dn_q  <= (dn_q | press_dn) & ~(o_dn_clr ? o_flr_pos : '0);
            flr_q <= (flr_q | press_flr) & ~(o_flr_clr ? o_flr_pos : '0) & ~withdraw_flr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_stop(input logic [NF-1:0] pos, input logic up, input logic dn,
                             input int open_cyc, input int dur);
        stop_t s;
        s.pos = pos; s.up = up; s.dn = dn; s.open_cyc = open_cyc; s.dur = dur;
        sb.push_back(s);
    endtask

    // Called at a negedge; returns the edge index at which the handler latched.
    task automatic press(input logic [NF-1:0] up, input logic [NF-1:0] dn,
                         input logic [NF-1:0] flr, output int q);
        press_up = up; press_dn = dn; press_flr = flr;
        @(posedge clk);
        #1;
        q = cyc;
        @(negedge clk);
        press_up = '0; press_dn = '0; press_flr = '0;
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pos"},  32'(o_flr_pos), 32'h001);
        chk({tag, "_door"}, 32'(o_door_open), 32'd0);
        chk({tag, "_mvup"}, 32'(o_move_up), 32'd0);
        chk({tag, "_mvdn"}, 32'(o_move_dn), 32'd0);
        chk({tag, "_clrs"}, 32'({o_up_clr, o_dn_clr, o_flr_clr}), 32'd0);
    endtask

    // Door-event monitor: pops the scoreboard on each opening, times each stay.
    always @(negedge clk) begin
        if (reset) begin
            door_prev = 1'b0;
        end else begin
            chk("move_excl", 32'(o_move_up & o_move_dn), 32'd0);
            if (o_door_open && !door_prev) begin
                chk("stop_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    cur_stop  = sb.pop_front();
                    open_seen = cyc;
                    $display("stop cycle=%0d pos=%03h up_clr=%0b dn_clr=%0b", cyc, o_flr_pos, o_up_clr, o_dn_clr);
                    chk("stop_pos",     32'(o_flr_pos), 32'(cur_stop.pos));
                    chk("stop_up_clr",  32'(o_up_clr),  32'(cur_stop.up));
                    chk("stop_dn_clr",  32'(o_dn_clr),  32'(cur_stop.dn));
                    chk("stop_flr_clr", 32'(o_flr_clr), 32'd1);
                    chk("stop_cycle",   32'(cyc), 32'(cur_stop.open_cyc));
                end
            end
            if (!o_door_open && door_prev) begin
                chk("door_dur", 32'(cyc - open_seen), 32'(cur_stop.dur));
            end
            door_prev = o_door_open;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int q;
        do_reset();
        chk_reset_vals("rst");

        // Car request at floor 5 from floor 0.
        press('0, '0, 12'h020, q);
        push_stop(12'h020, 1'b1, 1'b1, q + 21, 6);
        wait_until(q + 1);
        chk("a_mvup_start", 32'(o_move_up), 32'd1);
        chk("a_pos_start", 32'(o_flr_pos), 32'h001);
        wait_until(q + 4);
        chk("a_pos_before", 32'(o_flr_pos), 32'h001);
        wait_until(q + 5);
        chk("a_pos_first", 32'(o_flr_pos), 32'h002);
        wait_until(q + 20);
        chk("a_pos_f4", 32'(o_flr_pos), 32'h010);
        chk("a_mvup_f4", 32'(o_move_up), 32'd1);
        wait_until(q + 21);
        chk("a_mvup_arrive", 32'(o_move_up), 32'd0);
        wait_until(q + 27);
        chk("a_door_closed", 32'(o_door_open), 32'd0);
        chk("a_idle_outs", 32'({o_move_up, o_move_dn, o_up_clr, o_dn_clr, o_flr_clr}), 32'd0);
        chk("a_pos_end", 32'(o_flr_pos), 32'h020);

        // Hall-up request at the current floor opens the door next cycle.
        do_reset();
        chk_reset_vals("rst2");
        press(12'h001, '0, '0, q);
        push_stop(12'h001, 1'b1, 1'b0, q + 1, 6);
        wait_until(q + 1);
        chk("b_mvup", 32'(o_move_up), 32'd0);
        wait_until(q + 7);
        chk("b_door_closed", 32'(o_door_open), 32'd0);

        // Pass floor 3 going up, stop at 7, come back down to 3.
        press('0, 12'h008, 12'h080, q);
        push_stop(12'h080, 1'b1, 1'b1, q + 29, 6);
        push_stop(12'h008, 1'b1, 1'b1, q + 52, 6);
        wait_until(q + 13);
        chk("c_pass3_pos", 32'(o_flr_pos), 32'h008);
        chk("c_pass3_mvup", 32'(o_move_up), 32'd1);
        chk("c_pass3_door", 32'(o_door_open), 32'd0);
        wait_until(q + 29);
        chk("c_pos7", 32'(o_flr_pos), 32'h080);
        wait_until(q + 36);
        chk("c_mvdn", 32'(o_move_dn), 32'd1);
        chk("c_mvdn_door", 32'(o_door_open), 32'd0);
        wait_until(q + 52);
        chk("c_mvdn_arrive", 32'(o_move_dn), 32'd0);
        wait_until(q + 58);
        chk("c_door_closed", 32'(o_door_open), 32'd0);

        // Door hold for 10 cycles at floor 3.
        press(12'h008, '0, '0, q);
        push_stop(12'h008, 1'b1, 1'b0, q + 1, 16);
        wait_until(q + 1);
        door_hold = 1'b1;
        wait_until(q + 11);
        chk("d_held_open", 32'(o_door_open), 32'd1);
        door_hold = 1'b0;
        wait_until(q + 16);
        chk("d_still_open", 32'(o_door_open), 32'd1);
        wait_until(q + 17);
        chk("d_closed", 32'(o_door_open), 32'd0);

        // Request withdrawn during travel from floor 0.
        do_reset();
        chk_reset_vals("rst3");
        press('0, '0, 12'h100, q);
        wait_until(q + 2);
        withdraw_flr = 12'h100;
        @(negedge clk);
        withdraw_flr = '0;
        wait_until(q + 5);
        chk("e_pos", 32'(o_flr_pos), 32'h002);
        chk("e_mvup", 32'(o_move_up), 32'd0);
        chk("e_door", 32'(o_door_open), 32'd0);
        wait_until(q + 8);
        chk("e_idle", 32'({o_move_up, o_move_dn, o_door_open}), 32'd0);

        // Asynchronous reset in the middle of MOVE_UP.
        press('0, '0, 12'h800, q);
        wait_until(q + 3);
        chk("f_mvup", 32'(o_move_up), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("arst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_until(cyc + 3);
        chk("f_idle_after", 32'({o_move_up, o_door_open}), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
